// File: rtl/rpm_seq_multiplier_if.sv
// Start/operand request and result bundle for the shift-and-add multiplier core.
interface rpm_seq_multiplier_if #(
  parameter int WIDTH = 16
);
  logic                 start_i;
  logic [WIDTH-1:0]     a_i;
  logic [WIDTH-1:0]     b_i;
  logic                 ready_o;
  logic                 busy_o;
  logic                 done_o;
  logic [2*WIDTH-1:0]   product_o;

  modport master (
    output start_i, a_i, b_i,
    input  ready_o, busy_o, done_o, product_o
  );

  modport slave (
    input  start_i, a_i, b_i,
    output ready_o, busy_o, done_o, product_o
  );
endinterface

// File: rtl/rpm_seq_multiplier.sv
// Sequential Russian-peasant unsigned multiplier: one multiplier bit per cycle,
// addend picked through a 2:1 mux stage between zero and the shifted multiplicand.
module rpm_seq_multiplier #(
  parameter int WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  rpm_seq_multiplier_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [2*WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]     b_reg;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   product_q;

  logic                 mux_sel;
  logic [2*WIDTH-1:0]   mux_d0;
  logic [2*WIDTH-1:0]   mux_d1;
  logic [2*WIDTH-1:0]   mux_y;
  logic [2*WIDTH-1:0]   sum;
  logic                 last_bit;
  logic                 accept;

  // Mux stage: select is the multiplier LSB, data inputs are zero and the multiplicand.
  assign mux_sel  = b_reg[0];
  assign mux_d0   = '0;
  assign mux_d1   = a_reg;
  assign mux_y    = mux_sel ? mux_d1 : mux_d0;

  assign sum      = acc + mux_y;
  assign last_bit = (b_reg[WIDTH-1:1] == '0);
  assign accept   = (state == IDLE) && bus.start_i;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.start_i) state_nxt = (bus.b_i == '0) ? DONE : RUN;
      RUN:  if (last_bit)    state_nxt = DONE;
      DONE:                  state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Datapath; a reset mid-operation clears everything, including the held product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      acc       <= '0;
      product_q <= '0;
    end else if (accept) begin
      a_reg <= {{WIDTH{1'b0}}, bus.a_i};
      b_reg <= bus.b_i;
      acc   <= '0;
      if (bus.b_i == '0) product_q <= '0;
    end else if (state == RUN) begin
      acc   <= sum;
      a_reg <= a_reg << 1;
      b_reg <= b_reg >> 1;
      if (last_bit) product_q <= sum;
    end
  end

  assign bus.ready_o   = (state == IDLE);
  assign bus.busy_o    = (state != IDLE);
  assign bus.done_o    = (state == DONE);
  assign bus.product_o = product_q;

endmodule

// File: tb/tb_rpm_seq_multiplier.sv
// Bench for rpm_seq_multiplier: directed table, handshake/reset corner cases,
// and a random back-to-back regression against plain a*b with bit-length latency.
module tb_rpm_seq_multiplier;
  localparam int WIDTH = 16;
  localparam int MAXWAIT = 40;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;
  logic [2*WIDTH-1:0] last_prod;

  rpm_seq_multiplier_if #(.WIDTH(WIDTH)) bus ();

  rpm_seq_multiplier #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [2*WIDTH-1:0] prod;
    int                 lat;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference latency from accept edge to the done cycle: bit length of b, plus one.
  function automatic int model_lat(input logic [WIDTH-1:0] b);
    int k = 0;
    for (int i = 0; i < WIDTH; i++) if (b[i]) k = i + 1;
    return k + 1;
  endfunction

  function automatic logic [2*WIDTH-1:0] model_prod(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    longint unsigned p;
    p = longint'(a) * longint'(b);
    return p[2*WIDTH-1:0];
  endfunction

  task automatic wait_ready(input string name);
    int n = 0;
    @(negedge clk);
    while (!bus.ready_o && n < MAXWAIT) begin
      @(negedge clk);
      n++;
    end
    if (!bus.ready_o) check({name, "_ready_timeout"}, 64'(bus.ready_o), 64'd1);
  endtask

  // Launch one op from a negedge, count negedges until done, check product and latency.
  task automatic run_op(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [2*WIDTH-1:0] exp_prod, input int exp_lat);
    int lat = 0;
    wait_ready(name);
    bus.start_i = 1'b1;
    bus.a_i = a;
    bus.b_i = b;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    bus.a_i = WIDTH'($urandom);
    bus.b_i = WIDTH'($urandom);
    for (int c = 1; c <= MAXWAIT; c++) begin
      @(negedge clk);
      if (c == 1) check({name, "_busy"}, {62'd0, bus.busy_o, bus.ready_o}, 64'b10);
      if (bus.done_o) begin
        lat = c;
        break;
      end
      check({name, "_hold"}, 64'(bus.product_o), 64'(last_prod));
    end
    check({name, "_lat"}, 64'(lat), 64'(exp_lat));
    check({name, "_prod"}, 64'(bus.product_o), 64'(exp_prod));
    last_prod = exp_prod;
    @(negedge clk);
    check({name, "_after"}, {61'd0, bus.ready_o, bus.done_o, 1'b0}, 64'b100);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    last_prod = '0;
    bus.start_i = 1'b1;
    bus.a_i = 16'hAAAA;
    bus.b_i = 16'h5555;
    rst_n = 1'b0;

    tbl[0] = '{16'd13,   16'd11,   32'd143,        5};
    tbl[1] = '{16'hFFFF, 16'd0,    32'd0,          1};
    tbl[2] = '{16'd0,    16'd1,    32'd0,          2};
    tbl[3] = '{16'hFFFF, 16'hFFFF, 32'hFFFE0001,   17};
    tbl[4] = '{16'd1,    16'h8000, 32'h00008000,   17};
    tbl[5] = '{16'h8000, 16'h8000, 32'h40000000,   17};
    tbl[6] = '{16'd2,    16'd3,    32'd6,          3};
    tbl[7] = '{16'h1234, 16'd1,    32'h00001234,   2};

    repeat (3) @(negedge clk);
    check("reset_outputs", {bus.ready_o, bus.busy_o, bus.done_o, bus.product_o},
          {1'b1, 1'b0, 1'b0, 32'd0});
    bus.start_i = 1'b0;
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_op($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].prod, tbl[i].lat);

    // Starts while busy and in the DONE cycle must be ignored.
    begin
      int dones = 0;
      wait_ready("ignore");
      bus.start_i = 1'b1; bus.a_i = 16'd3; bus.b_i = 16'd5;
      @(posedge clk); #1;
      bus.start_i = 1'b0;
      @(posedge clk); #1;
      bus.start_i = 1'b1; bus.a_i = 16'd7; bus.b_i = 16'd9;
      @(posedge clk); #1;
      bus.start_i = 1'b0;
      @(negedge clk);
      check("ignore_notdone", 64'(bus.done_o), 64'd0);
      @(negedge clk);
      check("ignore_done", 64'(bus.done_o), 64'd1);
      check("ignore_prod", 64'(bus.product_o), 64'd15);
      bus.start_i = 1'b1; bus.a_i = 16'd7; bus.b_i = 16'd9;
      @(posedge clk); #1;
      bus.start_i = 1'b0;
      for (int c = 0; c < 12; c++) begin
        @(negedge clk);
        if (bus.done_o || !bus.ready_o) dones++;
      end
      check("ignore_no_second", 64'(dones), 64'd0);
      check("ignore_prod_held", 64'(bus.product_o), 64'd15);
      last_prod = 32'd15;
    end

    // Asynchronous reset mid-operation.
    begin
      int dones = 0;
      wait_ready("rst");
      bus.start_i = 1'b1; bus.a_i = 16'd100; bus.b_i = 16'd200;
      @(posedge clk); #1;
      bus.start_i = 1'b0;
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("rst_async", {bus.ready_o, bus.busy_o, bus.done_o, bus.product_o},
            {1'b1, 1'b0, 1'b0, 32'd0});
      repeat (2) begin
        @(negedge clk);
        if (bus.done_o) dones++;
      end
      rst_n = 1'b1;
      repeat (10) begin
        @(negedge clk);
        if (bus.done_o) dones++;
      end
      check("rst_no_done", 64'(dones), 64'd0);
      last_prod = '0;
      run_op("rst_after", 16'd2, 16'd3, 32'd6, 3);
    end

    // Back-to-back random regression with start held high.
    begin
      logic [WIDTH-1:0] a, b;
      int lat, got_lat;
      wait_ready("b2b");
      bus.start_i = 1'b1;
      for (int op = 0; op < 2500; op++) begin
        a = WIDTH'($urandom);
        b = WIDTH'($urandom) & WIDTH'((32'd1 << $urandom_range(0, WIDTH)) - 1);
        if (op % 7 == 0) a = '0;
        bus.a_i = a;
        bus.b_i = b;
        if (op > 0) begin
          @(negedge clk);
          check("b2b_idle", 64'(bus.ready_o), 64'd1);
        end
        lat = model_lat(b);
        got_lat = 0;
        for (int c = 1; c <= MAXWAIT; c++) begin
          @(negedge clk);
          if (bus.done_o) begin
            got_lat = c;
            break;
          end
          if (c == 1) check("b2b_hold", 64'(bus.product_o), 64'(last_prod));
        end
        check("b2b_lat", 64'(got_lat), 64'(lat));
        check("b2b_prod", 64'(bus.product_o), 64'(model_prod(a, b)));
        last_prod = model_prod(a, b);
        if (got_lat == 0) break;
      end
      bus.start_i = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
